add_arbiter: RTL

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter_pkg.sv | 18 +
 rtl/vsevenseg.sv | 33 +++
 rtl/add_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/add_arbiter_pkg.sv
// Shared types and constants for the two-requester adder arbiter.
package add_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef logic id_t;

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   function automatic logic [1:0] id_onehot(input id_t id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/vsevenseg.sv
// Hex to active-low seven-segment decoder; bit order {g,f,e,d,c,b,a}.
// Only compiled in when ADD_ARBITER_SEG_EN is defined.
`ifdef ADD_ARBITER_SEG_EN
module vsevenseg (
   input  logic [3:0] hex,
   output logic [6:0] seg_L
);

   always_comb begin
      seg_L = 7'b1111111;
      case (hex)
         4'h0: seg_L = 7'b1000000;
         4'h1: seg_L = 7'b1111001;
         4'h2: seg_L = 7'b0100100;
         4'h3: seg_L = 7'b0110000;
         4'h4: seg_L = 7'b0011001;
         4'h5: seg_L = 7'b0010010;
         4'h6: seg_L = 7'b0000010;
         4'h7: seg_L = 7'b1111000;
         4'h8: seg_L = 7'b0000000;
         4'h9: seg_L = 7'b0010000;
         4'ha: seg_L = 7'b0001000;
         4'hb: seg_L = 7'b0000011;
         4'hc: seg_L = 7'b1000110;
         4'hd: seg_L = 7'b0100001;
         4'he: seg_L = 7'b0000110;
         4'hf: seg_L = 7'b0001110;
         default: seg_L = 7'b1111111;
      endcase
   end

endmodule
`endif

// File: rtl/add_arbiter.sv
// Two-requester round-robin arbiter in front of a single W-bit adder.
// Optional seven-segment output of the sum: define ADD_ARBITER_SEG_EN.
module add_arbiter
   import add_arbiter_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [1:0]   req,
   input  logic [W-1:0] a0,
   input  logic [W-1:0] b0,
   input  logic [W-1:0] a1,
   input  logic [W-1:0] b1,
   output logic [1:0]   gnt,
   output logic [1:0]   done,
   output logic [W-1:0] sum,
   output logic         oflow,
   output logic [6:0]   seg_L,
   output logic [1:0]   fsm_state
);

   state_e       state;
   id_t          winner;
   id_t          last;
   id_t          pick;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic [W:0]   add_res;

   // On a tie the requester not served last wins; last only moves on DONE entry.
   always_comb begin
      pick = 1'b0;
      case (req)
         2'b01:   pick = 1'b0;
         2'b10:   pick = 1'b1;
         2'b11:   pick = ~last;
         default: pick = last;
      endcase
   end

   assign add_res = {1'b0, op_a} + {1'b0, op_b};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         winner <= 1'b0;
         last   <= 1'b1;
         op_a   <= '0;
         op_b   <= '0;
         sum    <= '0;
         oflow  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  state  <= CALC;
                  winner <= pick;
                  op_a   <= pick ? a1 : a0;
                  op_b   <= pick ? b1 : b0;
               end
            end
            CALC: begin
               state          <= DONE;
               {oflow, sum}   <= add_res;
               last           <= winner;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign gnt       = (state == CALC) ? id_onehot(winner) : 2'b00;
   assign done      = (state == DONE) ? id_onehot(winner) : 2'b00;
   assign fsm_state = state;

`ifdef ADD_ARBITER_SEG_EN
   logic [3:0] seg_hex;
   assign seg_hex = 4'(sum);

   vsevenseg u_seg (
      .hex   (seg_hex),
      .seg_L (seg_L)
   );
`else
   assign seg_L = SEG_OFF;
`endif

endmodule
